// File: rtl/tim_pkg.sv
// Shared timer definitions used by the time-base, prescaler and capture-compare blocks.
package tim_pkg;

   localparam int TIM_CNT_WIDTH = 16;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   typedef enum logic {ST_STOP, ST_RUN} tb_state_e;

endpackage

// File: rtl/arr_preload_reg.sv
// Active auto-reload register; captures arr_i whenever load_i is high.
module arr_preload_reg
   import tim_pkg::*;
#(
   parameter int CNT_WIDTH = TIM_CNT_WIDTH
) (
   input  logic                 clk_i,
   input  logic                 aresetn_i,
   input  logic                 load_i,
   input  logic [CNT_WIDTH-1:0] arr_i,
   output logic [CNT_WIDTH-1:0] arr_shadow_o
);

   always_ff @(posedge clk_i) begin
      if (!aresetn_i) begin
         arr_shadow_o <= '0;
      end else if (load_i) begin
         arr_shadow_o <= arr_i;
      end
   end

endmodule

// File: rtl/time_base_ctrl.sv
// Timer time-base: up/down main counter with auto-reload, one-pulse mode,
// update event generation and update-interrupt flag pulse.
module time_base_ctrl
   import tim_pkg::*;
#(
   parameter int CNT_WIDTH = TIM_CNT_WIDTH
) (
   input  logic                 clk_i,
   input  logic                 aresetn_i,
   input  logic                 psc_tick_i,
   input  logic                 cen_i,
   input  logic                 dir_i,
   input  logic                 opm_i,
   input  logic                 arpe_i,
   input  logic                 udis_i,
   input  logic                 urs_i,
   input  logic                 ug_i,
   input  logic [CNT_WIDTH-1:0] arr_i,
   output logic [CNT_WIDTH-1:0] cnt_o,
   output logic [CNT_WIDTH-1:0] arr_shadow_o,
   output logic                 uev_o,
   output logic                 uif_o,
   output logic                 cen_clr_o,
   output logic                 running_o
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   tb_state_e            state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0] arr_shadow;
   logic                 opm_lock_q, opm_lock_d;
   logic                 wrap, evt, opm_end, shadow_load;
   logic                 uev_q, uif_q, cen_clr_q;

   arr_preload_reg #(
      .CNT_WIDTH(CNT_WIDTH)
   ) u_arr_preload_reg (
      .clk_i       (clk_i),
      .aresetn_i   (aresetn_i),
      .load_i      (shadow_load),
      .arr_i       (arr_i),
      .arr_shadow_o(arr_shadow)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      opm_lock_d  = opm_lock_q;
      wrap        = 1'b0;

      if (state_q == ST_RUN && psc_tick_i) begin
         if (dir_i == DIR_UP) begin
            if (cnt_q == arr_shadow) begin
               wrap  = 1'b1;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end else begin
            if (cnt_q == '0) begin
               wrap  = 1'b1;
               cnt_d = arr_shadow;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
      end

      // A wrap coinciding with UG is a single event; UG wins the counter value.
      evt = (wrap | ug_i) & ~udis_i;
      if (evt && ug_i) begin
         cnt_d = (dir_i == DIR_UP) ? '0 : arr_i;
      end

      shadow_load = ~arpe_i | evt;
      opm_end     = opm_i & wrap & ~udis_i;

      if (state_q == ST_STOP) begin
         if (cen_i && !opm_lock_q) begin
            state_d = ST_RUN;
         end
      end else begin
         if (!cen_i || opm_end) begin
            state_d = ST_STOP;
         end
      end

      // After a one-pulse stop, CEN must be seen low before the counter may restart.
      if (opm_end) begin
         opm_lock_d = 1'b1;
      end else if (!cen_i) begin
         opm_lock_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!aresetn_i) begin
         state_q    <= ST_STOP;
         cnt_q      <= '0;
         opm_lock_q <= 1'b0;
         uev_q      <= 1'b0;
         uif_q      <= 1'b0;
         cen_clr_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         opm_lock_q <= opm_lock_d;
         uev_q      <= evt;
         uif_q      <= evt & (wrap | ~urs_i);
         cen_clr_q  <= opm_end;
      end
   end

   assign cnt_o        = cnt_q;
   assign arr_shadow_o = arr_shadow;
   assign uev_o        = uev_q;
   assign uif_o        = uif_q;
   assign cen_clr_o    = cen_clr_q;
   assign running_o    = (state_q == ST_RUN);

endmodule

// File: tb/tb_time_base_ctrl.sv
// Directed self-checking bench for time_base_ctrl with hand-computed expectations.
module tb_time_base_ctrl;

   logic        clk_i = 1'b0;
   logic        aresetn_i;
   logic        psc_tick_i;
   logic        cen_i;
   logic        dir_i;
   logic        opm_i;
   logic        arpe_i;
   logic        udis_i;
   logic        urs_i;
   logic        ug_i;
   logic [15:0] arr_i;
   logic [15:0] cnt_o;
   logic [15:0] arr_shadow_o;
   logic        uev_o;
   logic        uif_o;
   logic        cen_clr_o;
   logic        running_o;

   int nVectors     = 0;
   int nMiscompares = 0;

   int downCnt [8] = '{2, 2, 1, 1, 0, 0, 2, 2};
   int downUev [8] = '{1, 0, 0, 0, 0, 0, 1, 0};
   int preCnt  [10] = '{1, 2, 3, 0, 1, 2, 3, 4, 5, 0};
   int preShd  [10] = '{3, 3, 3, 5, 5, 5, 5, 5, 5, 5};
   int preUev  [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
   int dirCnt  [6] = '{1, 2, 3, 4, 5, 0};

   time_base_ctrl #(.CNT_WIDTH(16)) dut (
      .clk_i       (clk_i),
      .aresetn_i   (aresetn_i),
      .psc_tick_i  (psc_tick_i),
      .cen_i       (cen_i),
      .dir_i       (dir_i),
      .opm_i       (opm_i),
      .arpe_i      (arpe_i),
      .udis_i      (udis_i),
      .urs_i       (urs_i),
      .ug_i        (ug_i),
      .arr_i       (arr_i),
      .cnt_o       (cnt_o),
      .arr_shadow_o(arr_shadow_o),
      .uev_o       (uev_o),
      .uif_o       (uif_o),
      .cen_clr_o   (cen_clr_o),
      .running_o   (running_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nVectors++;
      if (obs !== exp) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   // One clock edge; outputs are then sampled 1 time unit after it.
   task automatic applyStimulus();
      @(posedge clk_i);
      #1;
   endtask

   task automatic doReset();
      aresetn_i  = 1'b0;
      cen_i      = 1'b0;
      psc_tick_i = 1'b0;
      dir_i      = 1'b0;
      opm_i      = 1'b0;
      arpe_i     = 1'b0;
      udis_i     = 1'b0;
      urs_i      = 1'b0;
      ug_i       = 1'b0;
      applyStimulus();
      aresetn_i  = 1'b1;
   endtask

   initial begin
      arr_i = 16'd3;
      doReset();
      aresetn_i = 1'b0;
      applyStimulus();
      checkOutput("rst_cnt", cnt_o, 0);
      checkOutput("rst_shadow", arr_shadow_o, 0);
      checkOutput("rst_uev", uev_o, 0);
      checkOutput("rst_uif", uif_o, 0);
      checkOutput("rst_cenclr", cen_clr_o, 0);
      checkOutput("rst_running", running_o, 0);

      // Up-count, ARR = 3, tick every cycle
      aresetn_i = 1'b1; cen_i = 1'b1; psc_tick_i = 1'b1;
      applyStimulus();
      checkOutput("up_running", running_o, 1);
      checkOutput("up_cnt_start", cnt_o, 0);
      checkOutput("up_shadow", arr_shadow_o, 3);
      for (int i = 1; i <= 3; i++) begin
         applyStimulus();
         checkOutput("up_cnt", cnt_o, i);
         checkOutput("up_uev_idle", uev_o, 0);
      end
      applyStimulus();
      checkOutput("up_wrap_cnt", cnt_o, 0);
      checkOutput("up_wrap_uev", uev_o, 1);
      checkOutput("up_wrap_uif", uif_o, 1);
      applyStimulus();
      checkOutput("up_after_cnt", cnt_o, 1);
      checkOutput("up_after_uev", uev_o, 0);

      // Down-count, ARR = 2, tick every second cycle
      doReset();
      arr_i = 16'd2; dir_i = 1'b1; cen_i = 1'b1;
      applyStimulus();
      checkOutput("dn_shadow", arr_shadow_o, 2);
      for (int i = 0; i < 8; i++) begin
         psc_tick_i = (i % 2 == 0);
         applyStimulus();
         checkOutput("dn_cnt", cnt_o, downCnt[i]);
         checkOutput("dn_uev", uev_o, downUev[i]);
      end

      // Preload on: ARR change mid-period takes effect after the next wrap
      doReset();
      arr_i = 16'd3; arpe_i = 1'b1; cen_i = 1'b1; ug_i = 1'b1;
      applyStimulus();
      checkOutput("pre_ug_shadow", arr_shadow_o, 3);
      checkOutput("pre_ug_uev", uev_o, 1);
      checkOutput("pre_ug_uif", uif_o, 1);
      ug_i = 1'b0; psc_tick_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         applyStimulus();
         if (i == 0) arr_i = 16'd5;
         checkOutput("pre_cnt", cnt_o, preCnt[i]);
         checkOutput("pre_shadow", arr_shadow_o, preShd[i]);
         checkOutput("pre_uev", uev_o, preUev[i]);
      end

      // Preload off: ARR change applies within the current period
      doReset();
      arr_i = 16'd3; cen_i = 1'b1; psc_tick_i = 1'b1;
      applyStimulus();
      for (int i = 0; i < 6; i++) begin
         applyStimulus();
         if (i == 0) arr_i = 16'd5;
         checkOutput("dir_cnt", cnt_o, dirCnt[i]);
      end
      checkOutput("dir_wrap_uev", uev_o, 1);

      // One-pulse: 0,1,2,0 then stop until CEN re-armed
      doReset();
      arr_i = 16'd2; opm_i = 1'b1; cen_i = 1'b1; psc_tick_i = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus();
      checkOutput("opm_cnt2", cnt_o, 2);
      applyStimulus();
      checkOutput("opm_end_cnt", cnt_o, 0);
      checkOutput("opm_end_uev", uev_o, 1);
      checkOutput("opm_end_cenclr", cen_clr_o, 1);
      checkOutput("opm_end_running", running_o, 0);
      applyStimulus();
      applyStimulus();
      checkOutput("opm_hold_cnt", cnt_o, 0);
      checkOutput("opm_hold_running", running_o, 0);
      checkOutput("opm_hold_cenclr", cen_clr_o, 0);
      checkOutput("opm_hold_uev", uev_o, 0);
      cen_i = 1'b0;
      applyStimulus();
      cen_i = 1'b1;
      applyStimulus();
      checkOutput("opm_rearm_running", running_o, 1);

      // UG with URS, then UDIS, then UG coincident with a wrap
      doReset();
      arr_i = 16'd3; urs_i = 1'b1; cen_i = 1'b1; psc_tick_i = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus();
      checkOutput("ug_pre_cnt", cnt_o, 2);
      ug_i = 1'b1;
      applyStimulus();
      ug_i = 1'b0;
      checkOutput("ug_cnt", cnt_o, 0);
      checkOutput("ug_uev", uev_o, 1);
      checkOutput("ug_urs_uif", uif_o, 0);
      applyStimulus();
      checkOutput("ug_after_cnt", cnt_o, 1);
      udis_i = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus();
      checkOutput("udis_wrap_cnt", cnt_o, 0);
      checkOutput("udis_uev", uev_o, 0);
      checkOutput("udis_uif", uif_o, 0);
      applyStimulus();
      checkOutput("udis_after_cnt", cnt_o, 1);
      udis_i = 1'b0; urs_i = 1'b0;
      applyStimulus();
      applyStimulus();
      checkOutput("ugw_pre_cnt", cnt_o, 3);
      ug_i = 1'b1;
      applyStimulus();
      ug_i = 1'b0;
      checkOutput("ugw_cnt", cnt_o, 0);
      checkOutput("ugw_uev", uev_o, 1);
      checkOutput("ugw_uif", uif_o, 1);
      applyStimulus();
      checkOutput("ugw_single_uev", uev_o, 0);
      checkOutput("ugw_after_cnt", cnt_o, 1);

      // Stop holds the counter; UG still acts while stopped
      cen_i = 1'b0;
      applyStimulus();
      checkOutput("stop_cnt", cnt_o, 2);
      checkOutput("stop_running", running_o, 0);
      applyStimulus();
      checkOutput("stop_hold_cnt", cnt_o, 2);
      ug_i = 1'b1;
      applyStimulus();
      ug_i = 1'b0;
      checkOutput("stop_ug_cnt", cnt_o, 0);
      checkOutput("stop_ug_uev", uev_o, 1);

      // ARR = 0: counter stays at 0 and wraps every tick
      doReset();
      arr_i = 16'd0; cen_i = 1'b1; psc_tick_i = 1'b1;
      applyStimulus();
      for (int i = 0; i < 2; i++) begin
         applyStimulus();
         checkOutput("arr0_cnt", cnt_o, 0);
         checkOutput("arr0_uev", uev_o, 1);
      end

      // Reset in the middle of a run
      doReset();
      arr_i = 16'd3; cen_i = 1'b1; psc_tick_i = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus();
      checkOutput("mid_pre_cnt", cnt_o, 2);
      aresetn_i = 1'b0;
      applyStimulus();
      checkOutput("mid_cnt", cnt_o, 0);
      checkOutput("mid_shadow", arr_shadow_o, 0);
      checkOutput("mid_uev", uev_o, 0);
      checkOutput("mid_uif", uif_o, 0);
      checkOutput("mid_running", running_o, 0);
      aresetn_i = 1'b1;
      applyStimulus();
      checkOutput("mid_restart_running", running_o, 1);
      checkOutput("mid_restart_shadow", arr_shadow_o, 3);

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
